// File: rtl/fft_pkg.sv
// Shared constants and sample/frame types for the 8-point FFT datapath.
// FFT_N     : frame length the FFT core is built for.
// FFT_W     : signed width of each real/imaginary component.
// FFT_LOG2N : width of a slot index within a frame.
package fft_pkg;

    localparam int FFT_N     = 8;
    localparam int FFT_W     = 16;
    localparam int FFT_LOG2N = 3;

    typedef logic signed [FFT_W-1:0] sample_t;
    typedef sample_t frame_t [FFT_N-1:0];

endpackage

// File: rtl/fft_frame_bank.sv
// One frame buffer of the ping-pong pair in front of the FFT core.
// Holds N complex samples plus full/padded flags.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   wr_en           write wr_re/wr_im into slot wr_idx this cycle
//   wr_idx          slot index of the write
//   wr_re, wr_im    sample being written
//   close           this write closes the frame (sets full)
//   pad             close is early: zero every slot above wr_idx
//   rd_clr          consumer took the frame; bank becomes empty
//   full, padded    bank state flags
//   frame_re/_im    stored frame contents, slot i = i-th sample
module fft_frame_bank #(
    parameter int N     = 8,
    parameter int W     = 16,
    parameter int LOG2N = $clog2(N)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [LOG2N-1:0]    wr_idx,
    input  logic signed [W-1:0] wr_re,
    input  logic signed [W-1:0] wr_im,
    input  logic                close,
    input  logic                pad,
    input  logic                rd_clr,
    output logic                full,
    output logic                padded,
    output logic signed [W-1:0] frame_re [N-1:0],
    output logic signed [W-1:0] frame_im [N-1:0]
);

    // The top never writes a full bank and never clears an empty one, so a
    // write and a clear never target the same bank in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            full   <= 1'b0;
            padded <= 1'b0;
            for (int i = 0; i < N; i++) begin
                frame_re[i] <= '0;
                frame_im[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                frame_re[wr_idx] <= wr_re;
                frame_im[wr_idx] <= wr_im;
                if (close) begin
                    full   <= 1'b1;
                    padded <= pad;
                    // Early close: the unused tail is zero-filled in the
                    // same cycle so the frame is complete when full rises.
                    if (pad) begin
                        for (int i = 0; i < N; i++) begin
                            if (i > int'(wr_idx)) begin
                                frame_re[i] <= '0;
                                frame_im[i] <= '0;
                            end
                        end
                    end
                end
            end
            if (rd_clr) begin
                full   <= 1'b0;
                padded <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/fft8_input_framer.sv
// Streaming front end for the 8-point parallel FFT core. Packs consecutive
// complex samples into N-sample frames (natural order) using two ping-pong
// banks, and presents each finished frame as parallel arrays.
//
// Handshakes (both sides): a transfer happens on a rising clk edge where
// valid and ready are both high. Valid, once raised, holds with its payload
// stable until the transfer. in_ready depends only on bank state (and reset),
// never on out_ready.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid/in_ready     input sample handshake
//   in_re, in_im          signed sample
//   in_last               close the current frame early (on accept only)
//   out_valid/out_ready   frame handshake
//   out_re, out_im        frame contents, element i = i-th accepted sample
//   out_padded            frame was zero-filled after an early in_last
// Outputs are forced to zero whenever out_valid is low.
module fft8_input_framer
    import fft_pkg::*;
#(
    parameter int N = FFT_N,    // power of two; the FFT core needs 8
    parameter int W = FFT_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] in_re,
    input  logic signed [W-1:0] in_im,
    input  logic                in_last,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [W-1:0] out_re [N-1:0],
    output logic signed [W-1:0] out_im [N-1:0],
    output logic                out_padded
);

    localparam int LOG2N = $clog2(N);

    logic             wr_bank;
    logic             rd_bank;
    logic [LOG2N-1:0] fill_idx;

    logic [1:0]       full;
    logic [1:0]       padded;
    logic signed [W-1:0] b0_re [N-1:0];
    logic signed [W-1:0] b0_im [N-1:0];
    logic signed [W-1:0] b1_re [N-1:0];
    logic signed [W-1:0] b1_im [N-1:0];

    logic accept;
    logic xfer;
    logic last_slot;
    logic close;
    logic pad;

    // Held low during reset so nothing is accepted while state is clearing.
    assign in_ready  = !rst && !full[wr_bank];
    assign accept    = in_valid && in_ready;
    assign xfer      = out_valid && out_ready;
    assign last_slot = (fill_idx == LOG2N'(N-1));
    assign close     = accept && (last_slot || in_last);
    // in_last on the final slot is an ordinary close, not a padded one.
    assign pad       = in_last && !last_slot;

    fft_frame_bank #(.N(N), .W(W), .LOG2N(LOG2N)) u_bank0 (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (accept && (wr_bank == 1'b0)),
        .wr_idx   (fill_idx),
        .wr_re    (in_re),
        .wr_im    (in_im),
        .close    (close),
        .pad      (pad),
        .rd_clr   (xfer && (rd_bank == 1'b0)),
        .full     (full[0]),
        .padded   (padded[0]),
        .frame_re (b0_re),
        .frame_im (b0_im)
    );

    fft_frame_bank #(.N(N), .W(W), .LOG2N(LOG2N)) u_bank1 (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (accept && (wr_bank == 1'b1)),
        .wr_idx   (fill_idx),
        .wr_re    (in_re),
        .wr_im    (in_im),
        .close    (close),
        .pad      (pad),
        .rd_clr   (xfer && (rd_bank == 1'b1)),
        .full     (full[1]),
        .padded   (padded[1]),
        .frame_re (b1_re),
        .frame_im (b1_im)
    );

    // A close on one bank and a transfer from the other can coincide; the
    // two pointers move independently so neither event is lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_bank  <= 1'b0;
            rd_bank  <= 1'b0;
            fill_idx <= '0;
        end else begin
            if (accept) begin
                if (close) begin
                    fill_idx <= '0;
                    wr_bank  <= ~wr_bank;
                end else begin
                    fill_idx <= fill_idx + 1'b1;
                end
            end
            if (xfer) begin
                rd_bank <= ~rd_bank;
            end
        end
    end

    always_comb begin
        out_valid  = full[rd_bank];
        out_padded = out_valid && padded[rd_bank];
        for (int i = 0; i < N; i++) begin
            out_re[i] = '0;
            out_im[i] = '0;
            if (out_valid) begin
                out_re[i] = rd_bank ? b1_re[i] : b0_re[i];
                out_im[i] = rd_bank ? b1_im[i] : b0_im[i];
            end
        end
    end

endmodule

// File: tb/tb_fft8_input_framer.sv
module tb_fft8_input_framer;
    import fft_pkg::*;

    localparam int N  = FFT_N;
    localparam int W  = FFT_W;
    localparam int FW = 2*N*W + 1;

    // ---------------- clock / reset / DUT ----------------
    logic    clk = 1'b0;
    logic    rst;
    logic    in_valid;
    logic    in_ready;
    sample_t in_re;
    sample_t in_im;
    logic    in_last;
    logic    out_valid;
    logic    out_ready;
    sample_t out_re [N-1:0];
    sample_t out_im [N-1:0];
    logic    out_padded;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    fft8_input_framer dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_re      (in_re),
        .in_im      (in_im),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_re     (out_re),
        .out_im     (out_im),
        .out_padded (out_padded)
    );

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [FW-1:0] exp_q [$];
    int xfer_q [$];
    frame_t m_re;
    frame_t m_im;
    int m_idx = 0;
    int last_acc_cyc = 0;
    int stall_cnt = 0;

    function automatic logic [FW-1:0] pack_frame(input logic pad, input frame_t re, input frame_t im);
        logic [FW-1:0] v;
        v = '0;
        v[FW-1] = pad;
        for (int i = 0; i < N; i++) begin
            v[i*W +: W]     = re[i];
            v[(N+i)*W +: W] = im[i];
        end
        return v;
    endfunction

    // Reference framing model, fed on each accepted sample.
    task automatic model_accept(input sample_t re, input sample_t im, input logic last);
        logic pad;
        m_re[m_idx] = re;
        m_im[m_idx] = im;
        if (m_idx == N-1 || last) begin
            pad = last && (m_idx < N-1);
            for (int i = m_idx + 1; i < N; i++) begin
                m_re[i] = '0;
                m_im[i] = '0;
            end
            exp_q.push_back(pack_frame(pad, m_re, m_im));
            m_idx = 0;
        end else begin
            m_idx++;
        end
    endtask

    // ---------------- driver tasks ----------------
    // Presents one sample and returns #1 after the edge that accepted it,
    // leaving in_valid high so consecutive calls stream without gaps.
    task automatic drive_sample(input int re, input int im, input logic last);
        logic acc;
        in_valid = 1'b1;
        in_re    = sample_t'(re);
        in_im    = sample_t'(im);
        in_last  = last;
        acc = 1'b0;
        for (int k = 0; k < 100 && !acc; k++) begin
            @(negedge clk);
            acc = in_ready;
            if (!acc) stall_cnt++;
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (!acc) begin
            n_fail++;
            $display("FAIL drive_timeout: sample re=%0d not accepted, in_ready=%b expected 1 within 100 cycles", re, in_ready);
        end else begin
            last_acc_cyc = cyc;
            model_accept(sample_t'(re), sample_t'(im), last);
        end
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 300 && exp_q.size() != 0; k++) @(posedge clk);
        @(posedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d frames still expected, required 0", exp_q.size());
        end
    endtask

    // ---------------- output monitor ----------------
    always @(negedge clk) begin
        logic [FW-1:0] act;
        logic [FW-1:0] exp;
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            act = pack_frame(out_padded, out_re, out_im);
            xfer_q.push_back(cyc + 1);
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL frame_unexpected: got %h, required no frame", act);
            end else begin
                exp = exp_q.pop_front();
                if (act !== exp) begin
                    n_fail++;
                    $display("FAIL frame_data: got %h required %h", act, exp);
                end
            end
        end
    end

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [FW-1:0] act;
        rst = 1'b1;
        in_valid = 1'b0; in_last = 1'b0; in_re = '0; in_im = '0;
        out_ready = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b required 0", in_ready); end
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
        act = pack_frame(out_padded, out_re, out_im);
        n_checks++;
        if (act !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h required 0", act); end
        @(posedge clk); #1;
        rst = 1'b0;
        m_idx = 0;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready: got %b required 1", in_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        xfer_q.delete();
        for (int i = 1; i <= 8; i++) drive_sample(i, -i, 1'b0);
        idle();
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_latency: out_valid=%b required 1", out_valid); end
        n_checks++;
        if (out_padded !== 1'b0) begin n_fail++; $display("FAIL b2b_padded: got %b required 0", out_padded); end
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_one_cycle: out_valid=%b required 0", out_valid); end
        @(posedge clk); #1;
        wait_drain();
    endtask

    task automatic test_early_close();
        out_ready = 1'b1;
        drive_sample(10, 1, 1'b0);
        drive_sample(20, 2, 1'b0);
        drive_sample(30, 3, 1'b1);
        idle();
        @(negedge clk);
        n_checks++;
        if (out_padded !== 1'b1) begin n_fail++; $display("FAIL early_padded: got %b required 1", out_padded); end
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) drive_sample(40 + i, 100 + i, 1'b0);
        idle();
        wait_drain();
    endtask

    task automatic test_backpressure();
        int acc17;
        acc17 = 0;
        out_ready = 1'b0;
        xfer_q.delete();
        for (int i = 1; i <= 16; i++) drive_sample(i, 1000 + i, 1'b0);
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_low: got %b required 0", in_ready); end
        @(posedge clk); #1;
        fork
            begin
                drive_sample(17, 1017, 1'b0);
                acc17 = last_acc_cyc;
                for (int i = 18; i <= 24; i++) drive_sample(i, 1000 + i, 1'b0);
                idle();
            end
            begin
                repeat (3) begin @(posedge clk); #1; end
                out_ready = 1'b1;
            end
        join
        wait_drain();
        n_checks++;
        if (xfer_q.size() != 3) begin n_fail++; $display("FAIL bp_frames: got %0d required 3", xfer_q.size()); end
        if (xfer_q.size() >= 2) begin
            n_checks++;
            if (acc17 != xfer_q[0] + 1) begin n_fail++; $display("FAIL bp_resume: accept cycle %0d required %0d", acc17, xfer_q[0] + 1); end
            n_checks++;
            if (xfer_q[1] != xfer_q[0] + 1) begin n_fail++; $display("FAIL bp_consecutive: second transfer %0d required %0d", xfer_q[1], xfer_q[0] + 1); end
        end
    endtask

    task automatic test_sustained();
        int bad;
        bad = 0;
        out_ready = 1'b1;
        xfer_q.delete();
        stall_cnt = 0;
        for (int i = 0; i < 64; i++) drive_sample(i*3 - 50, 7*i, 1'b0);
        idle();
        wait_drain();
        n_checks++;
        if (stall_cnt != 0) begin n_fail++; $display("FAIL sustained_stall: in_ready low %0d times required 0", stall_cnt); end
        n_checks++;
        if (xfer_q.size() != 8) begin n_fail++; $display("FAIL sustained_frames: got %0d required 8", xfer_q.size()); end
        for (int k = 1; k < xfer_q.size(); k++) if (xfer_q[k] - xfer_q[k-1] != 8) bad++;
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL sustained_spacing: %0d gaps not 8 cycles, required 0", bad); end
    endtask

    task automatic test_reset_mid_fill();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) drive_sample(200 + i, 5 + i, 1'b0);
        idle();
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_in_ready: got %b required 0", in_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        m_idx = 0;
        exp_q.delete();
        xfer_q.delete();
        repeat (10) begin @(posedge clk); #1; end
        n_checks++;
        if (xfer_q.size() != 0) begin n_fail++; $display("FAIL midrst_no_frame: got %0d frames required 0", xfer_q.size()); end
        for (int i = 100; i <= 107; i++) drive_sample(i, -i, 1'b0);
        idle();
        wait_drain();
        n_checks++;
        if (xfer_q.size() != 1) begin n_fail++; $display("FAIL midrst_clean_frame: got %0d frames required 1", xfer_q.size()); end
    endtask

    task automatic test_edge_closes();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) drive_sample(300 + i, i, (i == 7));
        idle();
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1 || out_padded !== 1'b0) begin
            n_fail++; $display("FAIL last_on_slot7: valid=%b padded=%b required 1/0", out_valid, out_padded);
        end
        @(posedge clk); #1;
        wait_drain();
        drive_sample(-32768, 5, 1'b1);
        idle();
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1 || out_padded !== 1'b1) begin
            n_fail++; $display("FAIL last_on_slot0: valid=%b padded=%b required 1/1", out_valid, out_padded);
        end
        @(posedge clk); #1;
        wait_drain();
        // random input gaps and output stalls
        for (int i = 0; i < 24; i++) begin
            drive_sample(int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 65535)) - 32768, 1'b0);
            idle();
            out_ready = 1'($urandom_range(0, 1));
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        end
        out_ready = 1'b1;
        wait_drain();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_back_to_back();
        test_early_close();
        test_backpressure();
        test_sustained();
        test_reset_mid_fill();
        test_edge_closes();
        repeat (3) begin @(posedge clk); #1; end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
